// File: rtl/fifo_flops_pkg.sv
// rtl/fifo_flops_pkg.sv - shared width helper and reset values for the flop-based FIFO
package fifo_flops_pkg;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer must index 0..depth-1; keep at least one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam logic [63:0] DOUT_RST_VAL = 64'h0;
    localparam logic        FLAG_RST_VAL = 1'b0;

endpackage

// File: rtl/fifo_flops_ptr.sv
// rtl/fifo_flops_ptr.sv - modulo-depth pointer counter with increment enable
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, forces ptr to 0
//   inc  - advance pointer by one this edge
//   ptr  - current pointer, wraps from depth-1 to 0
module fifo_flops_ptr
    import fifo_flops_pkg::*;
#(
    parameter int depth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    output logic [ptr_w(depth)-1:0]   ptr
);

    localparam int PW = ptr_w(depth);
    localparam logic [PW-1:0] LAST = PW'(depth - 1);

    // Explicit wrap compare so non-power-of-two depths never index past the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == LAST) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_flops_v2.sv
// rtl/fifo_flops_v2.sv - synchronous flop-array FIFO with registered read data and status flags
//
// Build option: define FIFO_FLOPS_ERR_EN to get sticky overflow/underflow flags
// cleared by clr_err; otherwise both flags are tied low and clr_err is ignored.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   push, Din    - write request and data
//   pop          - read request; Dout updates on the edge of an accepted pop
//   clr_err      - synchronous clear of sticky error flags
//   Dout         - registered read data, held when no pop is accepted
//   full, empty, almost_full, almost_empty - decoded from registered count
//   count        - occupancy 0..depth
//   overflow     - sticky, push rejected while full
//   underflow    - sticky, pop rejected while empty
module fifo_flops_v2
    import fifo_flops_pkg::*;
#(
    parameter int depth    = 16,
    parameter int bits     = 8,
    parameter int af_level = depth - 2,
    parameter int ae_level = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [bits-1:0]           Din,
    input  logic                      clr_err,
    output logic [bits-1:0]           Dout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [count_w(depth)-1:0] count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int CW = count_w(depth);
    localparam int PW = ptr_w(depth);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(af_level);
    localparam logic [CW-1:0] AE_C    = CW'(ae_level);

    logic [bits-1:0] mem [depth];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            push_ok;
    logic            pop_ok;

    // A push into a full FIFO is still fine when a pop frees the head slot on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    fifo_flops_ptr #(.depth(depth)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .ptr (wptr)
    );

    fifo_flops_ptr #(.depth(depth)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .ptr (rptr)
    );

    // Storage is deliberately not reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= Din;
        end
    end

    // When full, wptr == rptr: the read samples the old entry before the write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Dout <= DOUT_RST_VAL[bits-1:0];
        end else if (pop_ok) begin
            Dout <= mem[rptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count <= count - CW'(1);
        end
    end

`ifdef FIFO_FLOPS_ERR_EN
    // Setting takes priority over clr_err so an error in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= FLAG_RST_VAL;
            underflow <= FLAG_RST_VAL;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = FLAG_RST_VAL;
    assign underflow      = FLAG_RST_VAL;
`endif

endmodule

// File: tb/tb_fifo_flops_v2.sv
// tb/tb_fifo_flops_v2.sv - directed self-checking bench for fifo_flops_v2
module tb_fifo_flops_v2;

    localparam int DEPTH = 16;
    localparam int BITS  = 8;
    localparam int CW    = 5;

`ifdef FIFO_FLOPS_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            push;
    logic            pop;
    logic [BITS-1:0] Din;
    logic            clr_err;
    logic [BITS-1:0] Dout;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic            almost_empty;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            underflow;

    int vectors;
    int miscompares;

    fifo_flops_v2 #(
        .depth    (DEPTH),
        .bits     (BITS),
        .af_level (14),
        .ae_level (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .Din          (Din),
        .clr_err      (clr_err),
        .Dout         (Dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic p, input logic q, input logic [BITS-1:0] d, input logic c);
        push    = p;
        pop     = q;
        Din     = d;
        clr_err = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0; push = 1'b0; pop = 1'b0; Din = '0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_ae", 64'(almost_empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_dout", 64'(Dout), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_unf", 64'(underflow), 64'd0);
        #3 rst = 1'b1;

        // Fill 0..15
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, BITS'(i), 1'b0);
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_af", 64'(almost_full), 64'((i + 1) >= 14));
            check("fill_full", 64'(full), 64'((i + 1) == 16));
            check("fill_ae", 64'(almost_empty), 64'((i + 1) <= 2));
            check("fill_empty", 64'(empty), 64'd0);
        end
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        check("ovf_count", 64'(count), 64'd16);
        check("ovf_flag", 64'(overflow), 64'(ERR));
        check("ovf_full", 64'(full), 64'd1);

        // Drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            check("drain_dout", 64'(Dout), 64'(i));
            check("drain_count", 64'(count), 64'(15 - i));
        end
        check("drain_empty", 64'(empty), 64'd1);
        step(1'b0, 1'b1, '0, 1'b0);
        check("unf_flag", 64'(underflow), 64'(ERR));
        check("unf_dout_hold", 64'(Dout), 64'd15);
        check("unf_ovf_sticky", 64'(overflow), 64'(ERR));
        step(1'b0, 1'b0, '0, 1'b1);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_unf", 64'(underflow), 64'd0);

        // Simultaneous push/pop while full, then wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, BITS'(i), 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check("pp_full_dout", 64'(Dout), 64'd0);
        check("pp_full_count", 64'(count), 64'd16);
        check("pp_full_ovf", 64'(overflow), 64'd0);
        check("pp_full_full", 64'(full), 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            check("wrap_dout", 64'(Dout), 64'(i));
        end
        step(1'b0, 1'b1, '0, 1'b0);
        check("wrap_last", 64'(Dout), 64'h55);
        check("wrap_empty", 64'(empty), 64'd1);

        // Simultaneous push/pop while empty
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        check("pp_empty_count", 64'(count), 64'd1);
        check("pp_empty_unf", 64'(underflow), 64'(ERR));
        check("pp_empty_dout", 64'(Dout), 64'h55);
        step(1'b0, 1'b0, '0, 1'b1);
        check("pp_empty_clr", 64'(underflow), 64'd0);
        check("pp_empty_cnt2", 64'(count), 64'd1);
        step(1'b0, 1'b1, '0, 1'b0);
        check("pp_empty_read", 64'(Dout), 64'h3C);

        // Set wins over clear
        step(1'b0, 1'b1, '0, 1'b1);
        check("set_wins", 64'(underflow), 64'(ERR));
        step(1'b0, 1'b0, '0, 1'b1);
        check("set_wins_clr", 64'(underflow), 64'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, BITS'(8'hE0 + i), 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        check("pre_rst_dout", 64'(Dout), 64'hE0);
        check("pre_rst_count", 64'(count), 64'd4);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_dout", 64'(Dout), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h77, 1'b0);
        check("post_rst_count", 64'(count), 64'd1);
        step(1'b0, 1'b1, '0, 1'b0);
        check("post_rst_dout", 64'(Dout), 64'h77);
        check("post_rst_empty", 64'(empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
